// File: rtl/weight_serializer.sv
// Streams NUM_WORDS signed weight words from a parallel source memory, MSB first, onto a 1-bit line with WE strobe.
// Optional: define WEIGHT_SERIALIZER_CHECKSUM_EN to build the 16-bit running checksum of the words sent.
module weight_serializer #(
  parameter int WIDTH     = 10,
  parameter int NUM_WORDS = 65,
  parameter int AW        = 7
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Abort,
  output logic             RdEn,
  output logic [AW-1:0]    RdAddr,
  input  logic [WIDTH-1:0] RdData,
  output logic             SerOut,
  output logic             WE,
  output logic             Busy,
  output logic             Done,
  output logic [15:0]      Checksum
);

  // state   | meaning
  // S_IDLE  | waiting for Start
  // S_FETCH | RdEn high, RdAddr = word counter
  // S_LOAD  | RdData captured into shift register at end of cycle
  // S_SHIFT | WIDTH cycles of SerOut/WE
  // S_GAP   | one idle bit slot, then next word or finish
  // S_DONE  | one-cycle Done pulse
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

  localparam int            BW           = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [AW-1:0] LAST_WORD    = AW'(NUM_WORDS - 1);
  localparam logic [BW-1:0] LAST_BIT_CNT = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    word_q, word_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          word_d  = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_SHIFT;
        sr_d    = RdData;
        bit_d   = LAST_BIT_CNT;
      end
      S_SHIFT: begin
        // bit_q counts down the bits still to send after the current one
        if (bit_q == '0) begin
          state_d = S_GAP;
        end else begin
          bit_d = bit_q - 1'b1;
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        end
      end
      S_GAP: begin
        if (word_q < LAST_WORD) begin
          state_d = S_FETCH;
          word_d  = word_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (Abort) begin
      state_d = S_IDLE;
      word_d  = word_q;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      RdEn    <= 1'b0;
      RdAddr  <= '0;
      SerOut  <= 1'b0;
      WE      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      RdEn    <= (state_d == S_FETCH);
      RdAddr  <= word_d;
      SerOut  <= (state_d == S_SHIFT) & sr_d[WIDTH-1];
      WE      <= (state_d == S_SHIFT);
      Busy    <= (state_d != S_IDLE);
      Done    <= (state_d == S_DONE);
    end
  end

`ifdef WEIGHT_SERIALIZER_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (!Abort) begin
      if (state_q == S_IDLE && Start) begin
        chk_d = '0;
      end else if (state_q == S_LOAD) begin
        chk_d = chk_q + 16'(signed'(RdData));
      end
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) chk_q <= '0;
    else      chk_q <= chk_d;
  end

  assign Checksum = chk_q;
`else
  assign Checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_weight_serializer.sv
// Scoreboard bench for weight_serializer: expected bit/address/done events are queued at launch and popped by a monitor.
module tb_weight_serializer;
  localparam int WIDTH = 10;
  localparam int NW    = 65;
  localparam int AW    = 7;
  localparam int WPW   = WIDTH + 3;

  logic             Clock = 1'b0;
  logic             Rst   = 1'b0;
  logic             Start = 1'b0;
  logic             Abort = 1'b0;
  logic             RdEn;
  logic [AW-1:0]    RdAddr;
  logic [WIDTH-1:0] RdData = '0;
  logic             SerOut, WE, Busy, Done;
  logic [15:0]      Checksum;

  weight_serializer #(.WIDTH(WIDTH), .NUM_WORDS(NW), .AW(AW)) dut (
    .Clock(Clock), .Rst(Rst), .Start(Start), .Abort(Abort),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
    .SerOut(SerOut), .WE(WE), .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {int cyc; int val;} ev_t;
  ev_t bq[$];
  ev_t aq[$];
  ev_t dq[$];
  ev_t m_e;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int rd_cnt = 0;
  int busy_lo = -1;
  int busy_hi = -2;
  bit mon_en = 1'b0;

  logic [WIDTH-1:0] mem [NW];
  logic             rd_pend = 1'b0;
  logic [AW-1:0]    rd_addr_l = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_checksum();
    int s;
    s = 0;
    for (int n = 0; n < NW; n++)
      s += (int'(mem[n]) >= (1 << (WIDTH - 1))) ? int'(mem[n]) - (1 << WIDTH) : int'(mem[n]);
`ifdef WEIGHT_SERIALIZER_CHECKSUM_EN
    return s & 32'hFFFF;
`else
    return 0;
`endif
  endfunction

  // Source memory: data appears one cycle after the RdEn cycle, garbage otherwise
  always @(negedge Clock) begin
    if (rd_pend) RdData = mem[rd_addr_l];
    else         RdData = WIDTH'($urandom);
    rd_pend   = RdEn;
    rd_addr_l = RdAddr;
  end

  always @(negedge Clock) begin
    if (mon_en) begin
      chk("busy", int'(Busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (WE) begin
        we_cnt++;
        if (bq.size() == 0) chk("we_unexpected", 1, 0);
        else begin
          m_e = bq.pop_front();
          chk("we_cycle", cyc, m_e.cyc);
          chk("serout", int'(SerOut), m_e.val);
        end
      end
      if (RdEn) begin
        rd_cnt++;
        if (aq.size() == 0) chk("rden_unexpected", 1, 0);
        else begin
          m_e = aq.pop_front();
          chk("rd_cycle", cyc, m_e.cyc);
          chk("rd_addr", int'(RdAddr), m_e.val);
        end
      end
      if (Done) begin
        if (dq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          m_e = dq.pop_front();
          chk("done_cycle", cyc, m_e.cyc);
          chk("checksum_at_done", int'(Checksum), m_e.val);
        end
      end
    end
  end

  task automatic launch(output int e);
    @(negedge Clock);
    Start  = 1'b1;
    e      = cyc + 1;
    we_cnt = 0;
    rd_cnt = 0;
    for (int n = 0; n < NW; n++) begin
      aq.push_back('{e + WPW * n, n});
      for (int b = 0; b < WIDTH; b++)
        bq.push_back('{e + WPW * n + 2 + b, (int'(mem[n]) >> (WIDTH - 1 - b)) & 1});
    end
    dq.push_back('{e + NW * WPW, model_checksum()});
    busy_lo = e;
    busy_hi = e + NW * WPW;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic prune(input int last);
    while (bq.size() > 0 && bq[bq.size()-1].cyc > last) void'(bq.pop_back());
    while (aq.size() > 0 && aq[aq.size()-1].cyc > last) void'(aq.pop_back());
    while (dq.size() > 0 && dq[dq.size()-1].cyc > last) void'(dq.pop_back());
  endtask

  task automatic finish_xfer();
    int n;
    n = 0;
    while (dq.size() != 0 && n < NW * WPW + 50) begin
      @(negedge Clock);
      n++;
    end
    if (dq.size() != 0) begin
      chk("done_timeout", 0, 1);
      prune(-1);
    end
    @(negedge Clock);
    chk("busy_after_done", int'(Busy), 0);
    chk("bits_left", bq.size(), 0);
    chk("addr_left", aq.size(), 0);
    chk("we_count", we_cnt, NW * WIDTH);
    chk("rd_count", rd_cnt, NW);
    repeat (3) @(negedge Clock);
    chk("checksum_hold", int'(Checksum), model_checksum());
  endtask

  task automatic wait_cyc(input int tgt);
    int n;
    n = 0;
    while (cyc < tgt && n < 2000) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rden"}, int'(RdEn), 0);
    chk({tag, "_rdaddr"}, int'(RdAddr), 0);
    chk({tag, "_serout"}, int'(SerOut), 0);
    chk({tag, "_we"}, int'(WE), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_checksum"}, int'(Checksum), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int exp_c;
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Rst    = 1'b1;
    mon_en = 1'b1;

    // Word 0 = -411, rest random
    for (int n = 0; n < NW; n++) mem[n] = WIDTH'($urandom);
    mem[0] = 10'h265;
    launch(e);
    wait_cyc(e + 11);
    chk("w0_last_we", int'(WE), 1);
    chk("w0_last_bit", int'(SerOut), 1);
    @(negedge Clock);
    chk("w0_gap_we", int'(WE), 0);
    @(negedge Clock);
    chk("w1_fetch_addr", int'(RdAddr), 1);
    finish_xfer();

    // Address-as-data pattern
    for (int n = 0; n < NW; n++) mem[n] = WIDTH'(n);
    launch(e);
    finish_xfer();
`ifdef WEIGHT_SERIALIZER_CHECKSUM_EN
    exp_c = 2080;
`else
    exp_c = 0;
`endif
    chk("checksum_addr_pattern", int'(Checksum), exp_c);

    // All -1
    for (int n = 0; n < NW; n++) mem[n] = '1;
    launch(e);
    finish_xfer();
`ifdef WEIGHT_SERIALIZER_CHECKSUM_EN
    exp_c = 32'hFFBF;
`else
    exp_c = 0;
`endif
    chk("checksum_all_ones", int'(Checksum), exp_c);

    // Start re-pulsed while busy at word 10
    for (int n = 0; n < NW; n++) mem[n] = WIDTH'($urandom);
    launch(e);
    wait_cyc(e + WPW * 10 + 4);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    finish_xfer();

    // Abort during word 20 SHIFT
    launch(e);
    wait_cyc(e + WPW * 20 + 5);
    Abort   = 1'b1;
    busy_hi = cyc;
    exp_c   = cyc;
    @(posedge Clock);
    #1;
    prune(exp_c);
    @(negedge Clock);
    Abort = 1'b0;
    chk("abort_we", int'(WE), 0);
    chk("abort_rden", int'(RdEn), 0);
    chk("abort_busy", int'(Busy), 0);
    chk("abort_done", int'(Done), 0);
    repeat (15) @(negedge Clock);

    // Start and Abort together in IDLE
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    Abort = 1'b0;
    repeat (5) @(negedge Clock);
    chk("idle_start_abort_busy", int'(Busy), 0);

    for (int n = 0; n < NW; n++) mem[n] = WIDTH'($urandom);
    launch(e);
    finish_xfer();

    // Asynchronous reset at word 3, bit 4
    launch(e);
    wait_cyc(e + WPW * 3 + 6);
    #2;
    Rst = 1'b0;
    #1;
    check_all_zero("midreset");
    busy_hi = cyc;
    prune(-1);
    repeat (3) @(negedge Clock);
    Rst = 1'b1;
    repeat (20) @(negedge Clock);
    chk("post_reset_busy", int'(Busy), 0);
    chk("post_reset_rden", int'(RdEn), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
